// File: rtl/spi_reg_bank.sv
// Byte-serial SPI command engine: register bank with burst read/write, read-only
// result window, and a length-prefixed byte stream onto an AXI-Stream master.
module spi_reg_bank #(
    parameter  int NUM_REGS   = 16,
    parameter  int NUM_RESULT = 1,
    localparam int REG_AW     = $clog2(NUM_REGS),
    localparam int RES_AW     = (NUM_RESULT > 1) ? $clog2(NUM_RESULT) : 1
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    input  logic                    cs,
    input  logic [7:0]              mosi,
    output logic [7:0]              miso,
    output logic [8*NUM_REGS-1:0]   regs,
    input  logic [8*NUM_RESULT-1:0] results,
    output logic                    m_axis_tvalid,
    output logic [7:0]              m_axis_tdata,
    input  logic                    m_axis_tready
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, ST_LEN, ST_DATA
    } state_t;

    localparam logic [7:0]        CMD_READ   = 8'h03;
    localparam logic [7:0]        CMD_WRITE  = 8'h02;
    localparam logic [7:0]        CMD_STREAM = 8'h80;
    localparam logic [7:0]        CMD_STATUS = 8'h05;
    localparam logic [7:0]        CMD_CLEAR  = 8'h06;
    localparam logic [RES_AW-1:0] RES_MASK   = RES_AW'(NUM_RESULT - 1);

    state_t            state;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        res_arr [NUM_RESULT];
    logic [REG_AW-1:0] ptr;
    logic [RES_AW-1:0] rptr;
    logic              use_res;
    logic              discard;
    logic [7:0]        cnt;
    logic              overflow;
    logic              in_stream;
    logic              load;
    logic [REG_AW-1:0] addr_reg;
    logic [RES_AW-1:0] addr_res;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs[8*i +: 8] = regs_q[i];
    end

    for (genvar i = 0; i < NUM_RESULT; i++) begin : g_res
        assign res_arr[i] = results[8*i +: 8];
    end

    // NOTE: every signal written in an always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        in_stream = 1'b0;
        load      = 1'b0;
        if (cs && state == ST_DATA) begin
            in_stream = 1'b1;
            load      = !m_axis_tvalid || m_axis_tready;
        end
        addr_reg = mosi[REG_AW-1:0];
        addr_res = mosi[RES_AW-1:0] & RES_MASK;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other register.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            miso          <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            overflow      <= 1'b0;
            ptr           <= '0;
            rptr          <= '0;
            use_res       <= 1'b0;
            discard       <= 1'b0;
            cnt           <= 8'h00;
            // NOTE: the bank is reset because its contents are visible on the
            // regs port and must start known; plain RAMs normally are not.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            // The stream slot drains in every state, including while cs is low.
            if (load) begin
                m_axis_tdata  <= mosi;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (!cs) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        case (mosi)
                            CMD_READ:   state <= RD_ADDR;
                            CMD_WRITE:  state <= WR_ADDR;
                            CMD_STREAM: state <= ST_LEN;
                            CMD_STATUS: miso <= {overflow, m_axis_tvalid, 6'b0};
                            CMD_CLEAR:  overflow <= 1'b0;
                            default:    state <= IDLE;
                        endcase
                    end
                    RD_ADDR: begin
                        use_res <= mosi[7];
                        if (mosi[7]) begin
                            miso <= res_arr[addr_res];
                            rptr <= (addr_res + RES_AW'(1)) & RES_MASK;
                        end else begin
                            miso <= regs_q[addr_reg];
                            ptr  <= addr_reg + REG_AW'(1);
                        end
                        state <= RD_DATA;
                    end
                    RD_DATA: begin
                        if (use_res) begin
                            miso <= res_arr[rptr];
                            rptr <= (rptr + RES_AW'(1)) & RES_MASK;
                        end else begin
                            miso <= regs_q[ptr];
                            ptr  <= ptr + REG_AW'(1);
                        end
                    end
                    WR_ADDR: begin
                        // A result-space target is read-only: consume the burst, write nothing.
                        discard <= mosi[7];
                        ptr     <= addr_reg;
                        state   <= WR_DATA;
                    end
                    WR_DATA: begin
                        if (!discard) regs_q[ptr] <= mosi;
                        ptr <= ptr + REG_AW'(1);
                    end
                    ST_LEN: begin
                        if (mosi == 8'h00) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= mosi;
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (in_stream && !load) overflow <= 1'b1;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Byte-serial SPI command engine: one command/data byte is sampled on `mosi` per `sclk` rising edge.
- Provides a parametrised register bank with auto-incrementing burst read and burst write.
- Provides read-only access to a parametrised result vector.
- Provides a length-prefixed stream mode onto an AXI-Stream master with `tready` backpressure.
- A sticky overflow flag, readable via a status command, records stream bytes that were dropped.
- Sits between the SPI front end and the register-driven datapath plus the downstream stream consumer.

Parameters:
- NUM_REGS, 16, number of byte registers; power of two, 2..128.
- NUM_RESULT, 1, number of read-only result bytes; power of two, 1..128.
- REG_AW, $clog2(NUM_REGS), register index width (derived; do not override).
- RES_AW, $clog2(NUM_RESULT) (min 1), result index width (derived).

Ports:
- sclk  input  1  byte clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  transaction select, active high; low forces return to IDLE.
- mosi  input  8  command/address/data byte.
- miso  output  8  read data byte, registered.
- regs  output  8*NUM_REGS  register bank contents, flat; byte i at [8i+7:8i].
- results  input  8*NUM_RESULT  read-only result bytes, flat, same packing.
- m_axis_tvalid  output  1  stream byte valid.
- m_axis_tdata  output  8  stream byte.
- m_axis_tready  input  1  consumer ready, sampled on `sclk`.

Behaviour:
- Reset (async assert, sync-to-`sclk` release acceptable): state=IDLE; all regs=0x00; miso=0x00; m_axis_tvalid=0; m_axis_tdata=0x00; overflow=0; pointer/count=0.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, ST_LEN, ST_DATA.
- IDLE, decoded on the sampled `mosi` byte:
  - 0x03 -> RD_ADDR.
  - 0x02 -> WR_ADDR.
  - 0x80 -> ST_LEN.
  - 0x05 -> miso <= {overflow, m_axis_tvalid, 6'b0}; stay IDLE.
  - 0x06 -> overflow <= 0; stay IDLE.
  - Any other byte is ignored; stay IDLE.
- Address byte: bit7=1 selects the result space, index = addr[RES_AW-1:0]; bit7=0 selects the register space, index = addr[REG_AW-1:0]. Unused middle bits are ignored.
- RD_ADDR, edge with address A: miso <= byte(A) (latency 1 edge after the command byte); ptr <= index+1; -> RD_DATA.
- RD_DATA, each edge: miso <= byte(ptr); ptr <= ptr+1; `mosi` is ignored.
- WR_ADDR, edge with A: ptr <= index; -> WR_DATA.
  - If bit7=1, the write target is discarded: WR_DATA consumes bytes but writes nothing.
- WR_DATA, each edge: regs[ptr] <= mosi; ptr <= ptr+1.
- Pointer wrap: ptr wraps modulo NUM_REGS (register space) or NUM_RESULT (result space).
- Bursts of any length are legal in RD_DATA and WR_DATA; each continues until `cs` is low.
- ST_LEN, edge with L:
  - L=0 -> IDLE.
  - Otherwise cnt <= L; -> ST_DATA.
- ST_DATA, each edge, accept `mosi` as a stream byte:
  - If slot free (!m_axis_tvalid or m_axis_tready): tdata <= mosi; tvalid <= 1.
  - Else the byte is dropped and overflow <= 1; tvalid and tdata hold.
  - cnt <= cnt-1; cnt==1 -> IDLE after this byte.
- Stream drain, in any state: if m_axis_tvalid && m_axis_tready and no new byte is loaded on that edge, tvalid <= 0.
  - Drain continues after leaving ST_DATA and while `cs` is low.
- `cs` low at any edge:
  - State -> IDLE; the byte on `mosi` is not decoded and regs are not written.
  - miso holds its value; overflow holds.
- Reset mid-burst or mid-stream: all state is lost; tvalid drops immediately (async).
- overflow is sticky; it is cleared only by 0x06 or reset.

Test Plan:
- Burst write: cs=1, bytes 0x02,0x0E,0xA1,0xB2,0xC3 (NUM_REGS=16) -> regs[14]=0xA1, regs[15]=0xB2, regs[0]=0xC3 (wrap).
- Burst read, continuing the burst-write scenario: cs=1, bytes 0x03,0x0F,0x00,0x00 -> miso=0xB2, 0xC3, then regs[1]=0x00 on successive edges.
- Result read: NUM_RESULT=2, results={0x5A,0x3C}; bytes 0x03,0x80,xx,xx -> miso=0x3C, 0x5A, 0x3C (wrap).
- Stream, tready=1: bytes 0x80,0x03,0x11,0x22,0x33 -> tdata 0x11,0x22,0x33 with tvalid high 3 edges, then low; a following 0x03 is decoded as a READ command.
- Backpressure: tready=0, stream L=2 with bytes 0x44,0x55 -> tdata=0x44 held, overflow=1; command 0x05 -> miso=0xC0; raise tready -> tvalid drops; command 0x06, then 0x05 -> miso=0x00.
- Abort and reset: drop cs mid-WR_DATA, then byte 0x02 with cs=1 -> decoded as a new WRITE command, no stale write. Assert rst_n=0 with tvalid=1 -> tvalid=0 without a clock edge, all regs 0x00.
